// File: rtl/divider_sequencer.sv
// Iterative non-restoring unsigned divider: one quotient bit per clock through a
// single WIDTH+1-bit row of controlled add/subtract cells.
`timescale 1ns/1ps

// One controlled add/subtract cell: diag=1 subtracts b, diag=0 adds b.
module divider_cas_cell (
    input  logic a,
    input  logic b,
    input  logic diag,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic bx;

    // Invert b when subtracting; the row's carry-in supplies the +1.
    always_comb begin
        bx   = b ^ diag;
        s    = a ^ bx ^ cin;
        cout = (a & bx) | (a & cin) | (bx & cin);
    end
endmodule

module divider_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ITER    = 2'd1;
    localparam logic [1:0] S_CORRECT = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    // Operands presented to the shared add/subtract row.
    typedef struct packed {
        logic [WIDTH:0] a;
        logic [WIDTH:0] b;
        logic           diag;
    } row_req_t;

    logic [1:0]       state;
    logic [WIDTH:0]   p;      // signed partial remainder
    logic [WIDTH-1:0] q;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    cnt;

    row_req_t         row_req;
    logic [WIDTH:0]   row_sum;
    logic [WIDTH:0]   carry;

    // Row operands: shifted {P,Q} while iterating, plain P for the final fix-up add.
    always_comb begin
        row_req      = '0;
        row_req.a    = (state == S_ITER) ? {p[WIDTH-1:0], q[WIDTH-1]} : p;
        row_req.b    = {1'b0, d};
        row_req.diag = (state == S_ITER) && !p[WIDTH];
    end

    assign carry[0] = row_req.diag;

    // Ripple row; the MSB carry-out is discarded so the top bit is sum-only.
    for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_row
        if (gi < WIDTH) begin : g_cell
            divider_cas_cell u_cell (
                .a    (row_req.a[gi]),
                .b    (row_req.b[gi]),
                .diag (row_req.diag),
                .cin  (carry[gi]),
                .s    (row_sum[gi]),
                .cout (carry[gi+1])
            );
        end else begin : g_msb
            assign row_sum[gi] = row_req.a[gi] ^ row_req.b[gi] ^ row_req.diag ^ carry[gi];
        end
    end

    assign ready = (state == S_IDLE);
    assign busy  = (state == S_ITER) || (state == S_CORRECT);
    assign done  = (state == S_DONE);

    // Sequencer and datapath registers; results only move on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            p           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            p     <= '0;
                            q     <= dividend;
                            d     <= divisor;
                            cnt   <= '0;
                            state <= S_ITER;
                        end
                    end
                end
                S_ITER: begin
                    p   <= row_sum;
                    q   <= {q[WIDTH-2:0], ~row_sum[WIDTH]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1))
                        state <= S_CORRECT;
                end
                S_CORRECT: begin
                    if (p[WIDTH])
                        p <= row_sum;
                    quotient    <= q;
                    remainder   <= p[WIDTH] ? row_sum[WIDTH-1:0] : p[WIDTH-1:0];
                    div_by_zero <= 1'b0;
                    state       <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_divider_sequencer.sv
// Directed and randomized checks for divider_sequencer with a result scoreboard.
`timescale 1ns/1ps

module tb_divider_sequencer;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         ready, busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    divider_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // lat: index k of the edge e_k (e0 = accepting edge) after which done is high.
    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
        int           bc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc = 0;
    int   bcnt = 0;
    int   last_done = 0;
    bit   chk_space = 1'b0;
    bit   have_last = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q = '1; e.r = a; e.dbz = 1'b1; e.lat = 0; e.bc = 0;
        end else begin
            e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.lat = W + 1; e.bc = W + 1;
        end
        sb.push_back(e);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", {31'd0, ready}, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
        @(negedge clk);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
        wait_ready();
        start = 1'b1; dividend = a; divisor = b;
        push(a, b);
        @(negedge clk);
        start = 1'b0;
        wait_drain();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, {31'd0, ready}, 1);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_done"}, {31'd0, done}, 0);
        check({tag, "_quot"}, {24'd0, quotient}, 0);
        check({tag, "_rem"}, {24'd0, remainder}, 0);
        check({tag, "_dbz"}, {31'd0, div_by_zero}, 0);
    endtask

    // Acceptance tracking on the active edge (inputs are stable there).
    always @(posedge clk) begin
        if (rst_n && start && ready) begin
            acc  = cyc;
            bcnt = 0;
        end
        cyc++;
    end

    // Output monitor: invariants every cycle, scoreboard compare on done.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (busy) bcnt++;
            check("ready_and_busy", {31'd0, ready & busy}, 0);
            check("done_and_busy", {31'd0, done & busy}, 0);
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", {31'd0, done}, 0);
                end else begin
                    e = sb.pop_front();
                    check("quotient", {24'd0, quotient}, {24'd0, e.q});
                    check("remainder", {24'd0, remainder}, {24'd0, e.r});
                    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
                    check("latency", cyc - acc - 1, e.lat);
                    check("busy_cycles", bcnt, e.bc);
                    if (chk_space && have_last)
                        check("done_spacing", cyc - last_done, W + 3);
                    last_done = cyc;
                    have_last = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Main case and boundaries
        do_op(8'd100, 8'd7);
        do_op(8'd255, 8'd1);
        do_op(8'd5, 8'd9);
        do_op(8'd255, 8'd255);
        do_op(8'd0, 8'd13);

        // Divide by zero, then a normal op clears the flag
        do_op(8'd37, 8'd0);
        do_op(8'd37, 8'd5);

        // Starts during ITER and DONE are ignored
        wait_ready();
        start = 1'b1; dividend = 8'd200; divisor = 8'd3;
        push(8'd200, 8'd3);
        @(negedge clk);                 // cycle 0
        start = 1'b0;
        repeat (3) @(negedge clk);      // cycle 3
        start = 1'b1; dividend = 8'd9; divisor = 8'd2;
        @(negedge clk);                 // cycle 4
        start = 1'b0;
        repeat (5) @(negedge clk);      // cycle 9 (DONE)
        start = 1'b1;
        @(negedge clk);                 // cycle 10
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("hold_quot", {24'd0, quotient}, 66);
        check("hold_rem", {24'd0, remainder}, 2);
        check("no_extra_op", {31'd0, busy}, 0);
        check("sb_empty_busyprot", sb.size(), 0);

        // Reset mid-operation: results held until then, cleared asynchronously
        wait_ready();
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        push(8'd100, 8'd7);
        @(negedge clk);                 // cycle 0
        start = 1'b0;
        repeat (3) @(negedge clk);      // cycle 3
        check("mid_hold_quot", {24'd0, quotient}, 66);
        check("mid_hold_rem", {24'd0, remainder}, 2);
        @(negedge clk);                 // cycle 4
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        do_op(8'd50, 8'd6);

        // Randomized back-to-back with start held high
        chk_space = 1'b1;
        have_last = 1'b0;
        wait_ready();
        dividend = 8'($urandom_range(0, 255));
        divisor  = 8'($urandom_range(1, 255));
        start    = 1'b1;
        push(dividend, divisor);
        for (int i = 0; i < 1000; i++) begin
            wait_ready();
            @(negedge clk);             // accepted on the edge just passed
            if (i < 999) begin
                dividend = 8'($urandom_range(0, 255));
                divisor  = 8'($urandom_range(1, 255));
                push(dividend, divisor);
            end else begin
                start = 1'b0;
            end
        end
        wait_drain();
        chk_space = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
